// File: rtl/mem_burst_master.sv
// rtl/mem_burst_master.sv - burst command sequencer for a single-port valid/ready memory
//
// Accepts one burst command (start address, beat count, direction) and issues
// one memory transaction per beat, never more than one outstanding at a time.
// Write beats pull data from the wdata stream; read beats return data on the
// rdata stream, honouring downstream backpressure.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o         burst command handshake
//   cmd_wr_rd_i, cmd_addr_i, cmd_len_i  direction (1=write), start address, beat count
//   wdata_valid_i / wdata_ready_o / wdata_i   write-data stream in
//   rdata_valid_o / rdata_ready_i / rdata_o   read-data stream out
//   mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o   request to memory
//   mem_rdata_i, mem_ready_i          response from memory
//   busy_o                            high whenever a burst is in progress
//   done_o                            one-cycle pulse at burst completion
module mem_burst_master #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH:0]   cmd_len_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic                  rdata_valid_o,
  input  logic                  rdata_ready_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  input  logic                  mem_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_FETCH = 3'd1,
    S_WR_ISSUE = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_OUT   = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remain_q;
  logic                  wr_rd_q;
  logic [WIDTH-1:0]      wdata_q;
  logic [WIDTH-1:0]      rdata_q;

  logic                  cmd_fire;
  logic                  wdata_fire;
  logic                  mem_fire;
  logic                  rdata_fire;
  logic                  last_beat;
  logic [ADDR_WIDTH-1:0] addr_next;

  // Handshake events are decoded straight from the state register so the
  // ready/valid outputs never feed back into their own transfer condition.
  assign cmd_fire   = cmd_valid_i   && (state == S_IDLE) && !rst_i;
  assign wdata_fire = wdata_valid_i && (state == S_WR_FETCH);
  assign mem_fire   = mem_ready_i   && ((state == S_WR_ISSUE) || (state == S_RD_ISSUE));
  assign rdata_fire = rdata_ready_i && (state == S_RD_OUT);

  // The remaining count is decremented when a beat fully completes (memory
  // write accepted, or read data handed downstream), so 1 marks the last beat.
  assign last_beat = (remain_q == (ADDR_WIDTH+1)'(1));

  // Explicit wrap keeps the sequence correct even for a non-power-of-two DEPTH.
  assign addr_next = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    cmd_ready_o   = 1'b0;
    wdata_ready_o = 1'b0;
    mem_valid_o   = 1'b0;
    rdata_valid_o = 1'b0;
    busy_o        = 1'b1;
    done_o        = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready_o = !rst_i;
        busy_o      = 1'b0;
        if (cmd_fire) begin
          if (cmd_len_i == '0) begin
            state_next = S_DONE;
          end else if (cmd_wr_rd_i) begin
            state_next = S_WR_FETCH;
          end else begin
            state_next = S_RD_ISSUE;
          end
        end
      end
      S_WR_FETCH: begin
        wdata_ready_o = 1'b1;
        if (wdata_fire) begin
          state_next = S_WR_ISSUE;
        end
      end
      S_WR_ISSUE: begin
        mem_valid_o = 1'b1;
        if (mem_fire) begin
          state_next = last_beat ? S_DONE : S_WR_FETCH;
        end
      end
      S_RD_ISSUE: begin
        mem_valid_o = 1'b1;
        if (mem_fire) begin
          state_next = S_RD_OUT;
        end
      end
      S_RD_OUT: begin
        rdata_valid_o = 1'b1;
        if (rdata_fire) begin
          state_next = last_beat ? S_DONE : S_RD_ISSUE;
        end
      end
      S_DONE: begin
        done_o     = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q   <= '0;
      remain_q <= '0;
      wr_rd_q  <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      // Direction is asserted only while a write burst is in flight, so the
      // strobe returns low as soon as the burst ends.
      wr_rd_q <= (state_next == S_WR_FETCH) || (state_next == S_WR_ISSUE);

      if (cmd_fire) begin
        addr_q   <= cmd_addr_i;
        remain_q <= cmd_len_i;
      end

      if (wdata_fire) begin
        wdata_q <= wdata_i;
      end

      if (mem_fire) begin
        addr_q <= addr_next;
        if (state == S_RD_ISSUE) begin
          rdata_q <= mem_rdata_i;
        end
      end

      if ((mem_fire && (state == S_WR_ISSUE)) || rdata_fire) begin
        remain_q <= remain_q - (ADDR_WIDTH+1)'(1);
      end
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wr_rd_o = wr_rd_q;
  assign mem_wdata_o = wdata_q;
  assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// tb/tb_mem_burst_master.sv - self-checking bench for mem_burst_master
module tb_mem_burst_master;

  localparam int WIDTH = 16;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic             clk;
  logic             rst_i;
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic             cmd_wr_rd_i;
  logic [AW-1:0]    cmd_addr_i;
  logic [AW:0]      cmd_len_i;
  logic             wdata_valid_i;
  logic             wdata_ready_o;
  logic [WIDTH-1:0] wdata_i;
  logic             rdata_valid_o;
  logic             rdata_ready_i;
  logic [WIDTH-1:0] rdata_o;
  logic             mem_valid_o;
  logic             mem_wr_rd_o;
  logic [AW-1:0]    mem_addr_o;
  logic [WIDTH-1:0] mem_wdata_o;
  logic [WIDTH-1:0] mem_rdata_i;
  logic             mem_ready_i;
  logic             busy_o;
  logic             done_o;

  mem_burst_master #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_rd_i(cmd_wr_rd_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
    .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i), .rdata_o(rdata_o),
    .mem_valid_o(mem_valid_o), .mem_wr_rd_o(mem_wr_rd_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory peer contents and the reference model's view of what they should be.
  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] ref_mem [DEPTH];
  assign mem_rdata_i = mem[mem_addr_o];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic             wr;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } beat_t;

  beat_t            beats [$];
  logic [WIDTH-1:0] rds   [$];
  logic [WIDTH-1:0] wq    [$];
  int               done_cnt   = 0;
  int               valid_cnt  = 0;
  bit               xfer_w     = 1'b0;
  bit               rand_mem   = 1'b0;
  bit               rand_w     = 1'b0;
  bit               manual_rdy = 1'b0;

  // Monitor: mid-cycle, record every transfer that the coming edge completes.
  initial forever begin
    @(negedge clk);
    if (!rst_i) begin
      if (mem_valid_o) valid_cnt++;
      if (mem_valid_o && mem_ready_i) begin
        beats.push_back('{mem_wr_rd_o, mem_addr_o, mem_wdata_o});
        if (mem_wr_rd_o) mem[mem_addr_o] = mem_wdata_o;
      end
      if (rdata_valid_o && rdata_ready_i) rds.push_back(rdata_o);
      if (wdata_valid_i && wdata_ready_o) xfer_w = 1'b1;
      if (done_o) done_cnt++;
    end
  end

  // Peer drivers: just after each edge, advance the write stream and ready lines.
  initial forever begin
    @(posedge clk);
    #1;
    if (rst_i) begin
      wdata_valid_i = 1'b0;
      wq.delete();
      xfer_w = 1'b0;
    end else begin
      if (xfer_w) begin
        xfer_w = 1'b0;
        wdata_valid_i = 1'b0;
        wq.delete(0);
      end
      if (!wdata_valid_i && wq.size() > 0 && (!rand_w || $urandom_range(0, 1) == 1)) begin
        wdata_i = wq[0];
        wdata_valid_i = 1'b1;
      end
    end
    mem_ready_i = rand_mem ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!manual_rdy) rdata_ready_i = rand_mem ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic issue_cmd(input bit wr, input int addr, input int len);
    bit ok = 1'b0;
    tick();
    cmd_valid_i = 1'b1;
    cmd_wr_rd_i = wr;
    cmd_addr_i  = AW'(addr);
    cmd_len_i   = (AW+1)'(len);
    for (int i = 0; i < 20; i++) begin
      sample();
      if (cmd_ready_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    cmd_valid_i = 1'b0;
    if (!ok) check("cmd_accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_done(input int start, input int limit);
    bit ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      sample();
      if (done_cnt > start) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("done_timeout", 32'(0), 32'(1));
  endtask

  // Reference model: a burst touches (addr+i) mod DEPTH for i in 0..len-1.
  task automatic run_burst(input bit wr, input int addr, input int len,
                           output int first, output int last, output int nbeats);
    beat_t            exp_b  [$];
    logic [WIDTH-1:0] exp_rd [$];
    int               d0;
    int               a;
    logic [WIDTH-1:0] d;
    beats.delete();
    rds.delete();
    d0 = done_cnt;
    for (int i = 0; i < len; i++) begin
      a = (addr + i) % DEPTH;
      if (wr) begin
        d = 16'($urandom);
        wq.push_back(d);
        exp_b.push_back('{1'b1, AW'(a), d});
        ref_mem[a] = d;
      end else begin
        exp_b.push_back('{1'b0, AW'(a), 16'h0});
        exp_rd.push_back(ref_mem[a]);
      end
    end
    issue_cmd(wr, addr, len);
    wait_done(d0, len * 16 + 50);
    tick();
    tick();
    sample();
    check("done_once", 32'(done_cnt - d0), 32'(1));
    check("beat_count", 32'(beats.size()), 32'(len));
    for (int i = 0; i < len && i < beats.size(); i++) begin
      check($sformatf("beat%0d_addr", i), 32'(beats[i].addr), 32'(exp_b[i].addr));
      check($sformatf("beat%0d_dir", i), 32'(beats[i].wr), 32'(wr));
      if (wr) check($sformatf("beat%0d_wdata", i), 32'(beats[i].data), 32'(exp_b[i].data));
    end
    if (!wr) begin
      check("rdata_count", 32'(rds.size()), 32'(len));
      for (int i = 0; i < len && i < rds.size(); i++)
        check($sformatf("rdata%0d", i), 32'(rds[i]), 32'(exp_rd[i]));
    end
    nbeats = beats.size();
    first  = (beats.size() > 0) ? int'(beats[0].addr) : -1;
    last   = (beats.size() > 0) ? int'(beats[beats.size()-1].addr) : -1;
  endtask

  typedef struct {
    bit wr;
    int addr;
    int len;
    int exp_beats;
    int exp_first;
    int exp_last;
  } vec_t;

  initial begin
    vec_t             vecs [6];
    int               first, last, nb;
    int               d0, v0, wr, ad, ln;
    logic [WIDTH-1:0] held;
    logic [WIDTH-1:0] exp3 [3];
    logic [WIDTH-1:0] rdata_w [20];
    bit               ok;

    vecs[0] = '{1'b1,  0, 64, 64,  0, 63};
    vecs[1] = '{1'b0,  0, 64, 64,  0, 63};
    vecs[2] = '{1'b1, 62,  4,  4, 62,  1};
    vecs[3] = '{1'b0, 63,  2,  2, 63,  0};
    vecs[4] = '{1'b1, 10,  1,  1, 10, 10};
    vecs[5] = '{1'b0, 40, 70, 70, 40, 45};

    rst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_wr_rd_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
    wdata_valid_i = 1'b0; wdata_i = '0; rdata_ready_i = 1'b1; mem_ready_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end

    repeat (3) tick();
    sample();
    check("rst_cmd_ready_low", 32'(cmd_ready_o), 32'(0));
    tick();
    rst_i = 1'b0;
    sample();
    check("post_rst_cmd_ready", 32'(cmd_ready_o), 32'(1));
    check("post_rst_busy", 32'(busy_o), 32'(0));
    check("post_rst_done", 32'(done_o), 32'(0));
    check("post_rst_mem_valid", 32'(mem_valid_o), 32'(0));
    check("post_rst_streams", 32'({wdata_ready_o, rdata_valid_o, mem_wr_rd_o}), 32'(0));
    check("post_rst_regs", 32'({mem_addr_o, mem_wdata_o}) | 32'(rdata_o), 32'(0));

    for (int v = 0; v < 6; v++) begin
      run_burst(vecs[v].wr, vecs[v].addr, vecs[v].len, first, last, nb);
      check($sformatf("vec%0d_beats", v), 32'(nb), 32'(vecs[v].exp_beats));
      check($sformatf("vec%0d_first", v), 32'(first), 32'(vecs[v].exp_first));
      check($sformatf("vec%0d_last", v), 32'(last), 32'(vecs[v].exp_last));
    end
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("backdoor%0d", i), 32'(mem[i]), 32'(ref_mem[i]));

    // len=0: done the cycle after accept, no memory activity, ready again next.
    d0 = done_cnt;
    v0 = valid_cnt;
    tick();
    cmd_valid_i = 1'b1; cmd_wr_rd_i = 1'b1; cmd_addr_i = 6'd7; cmd_len_i = '0;
    sample();
    check("len0_accept", 32'(cmd_ready_o), 32'(1));
    tick();
    cmd_valid_i = 1'b0;
    sample();
    check("len0_done", 32'(done_o), 32'(1));
    check("len0_cmd_ready_busy", 32'(cmd_ready_o), 32'(0));
    tick();
    sample();
    check("len0_done_pulse", 32'(done_o), 32'(0));
    check("len0_cmd_ready_again", 32'(cmd_ready_o), 32'(1));
    check("len0_no_mem", 32'(valid_cnt - v0), 32'(0));
    check("len0_done_count", 32'(done_cnt - d0), 32'(1));

    // Backpressure: read len=3 from 20, stall beat 2 for 5 cycles.
    manual_rdy = 1'b1;
    rdata_ready_i = 1'b1;
    rds.delete();
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) exp3[i] = ref_mem[20 + i];
    tick();
    cmd_valid_i = 1'b1; cmd_wr_rd_i = 1'b0; cmd_addr_i = 6'd20; cmd_len_i = 7'd3;
    sample();
    check("bp_accept", 32'(cmd_ready_o), 32'(1));
    tick();
    cmd_valid_i = 1'b0;
    sample();
    check("bp_read_latency", 32'(mem_valid_o), 32'(1));
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rds.size() >= 1) begin ok = 1'b1; break; end
      tick();
      sample();
    end
    check("bp_beat1_seen", 32'(ok), 32'(1));
    tick();
    rdata_ready_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (rdata_valid_o) begin ok = 1'b1; break; end
      tick();
    end
    check("bp_beat2_valid", 32'(ok), 32'(1));
    held = rdata_o;
    check("bp_beat2_data", 32'(held), 32'(exp3[1]));
    v0 = valid_cnt;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_stall%0d_valid", k), 32'(rdata_valid_o), 32'(1));
      check($sformatf("bp_stall%0d_hold", k), 32'(rdata_o), 32'(held));
      check($sformatf("bp_stall%0d_busy", k), 32'({busy_o, cmd_ready_o}), 32'(2));
      tick();
      if (k < 4) sample();
    end
    check("bp_no_mem_in_stall", 32'(valid_cnt - v0), 32'(0));
    rdata_ready_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (rds.size() >= 3) begin ok = 1'b1; break; end
      tick();
    end
    check("bp_third_transfer", 32'(ok), 32'(1));
    tick();
    sample();
    check("bp_done_timing", 32'(done_o), 32'(1));
    check("bp_done_count", 32'(done_cnt - d0), 32'(1));
    for (int i = 0; i < 3 && i < rds.size(); i++)
      check($sformatf("bp_rdata%0d", i), 32'(rds[i]), 32'(exp3[i]));
    manual_rdy = 1'b0;

    // Reset after beat 10 of a write len=20 at address 5.
    beats.delete();
    d0 = done_cnt;
    for (int i = 0; i < 20; i++) begin
      rdata_w[i] = 16'($urandom);
      wq.push_back(rdata_w[i]);
    end
    issue_cmd(1'b1, 5, 20);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      sample();
      if (beats.size() >= 10) begin ok = 1'b1; break; end
      tick();
    end
    check("rst_mid_reach_beat10", 32'(ok), 32'(1));
    tick();
    rst_i = 1'b1;
    sample();
    tick();
    sample();
    check("rst_mid_mem_valid", 32'(mem_valid_o), 32'(0));
    check("rst_mid_busy_done", 32'({busy_o, done_o}), 32'(0));
    check("rst_mid_cmd_ready", 32'(cmd_ready_o), 32'(0));
    check("rst_mid_streams", 32'({wdata_ready_o, rdata_valid_o, mem_wr_rd_o}), 32'(0));
    check("rst_mid_regs", 32'({mem_addr_o, mem_wdata_o}), 32'(0));
    tick();
    rst_i = 1'b0;
    sample();
    check("rst_mid_cmd_ready_after", 32'(cmd_ready_o), 32'(1));
    for (int i = 0; i < 10; i++) ref_mem[5 + i] = rdata_w[i];
    repeat (20) tick();
    sample();
    check("rst_mid_no_done", 32'(done_cnt - d0), 32'(0));
    check("rst_mid_beats", 32'(beats.size()), 32'(10));
    run_burst(1'b0, 5, 12, first, last, nb);

    // Randomised bursts with random peer stalls.
    rand_mem = 1'b1;
    rand_w   = 1'b1;
    for (int n = 0; n < 8; n++) begin
      wr = $urandom_range(0, 1);
      ad = $urandom_range(0, DEPTH - 1);
      ln = $urandom_range(0, 2 * DEPTH - 1);
      run_burst(wr[0], ad, ln, first, last, nb);
    end
    rand_mem = 1'b0;
    rand_w   = 1'b0;
    tick();
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("final_mem%0d", i), 32'(mem[i]), 32'(ref_mem[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_burst_master.md
# mem_burst_master

Upstream command sequencer for the single-port valid/ready memory (WIDTH=16, DEPTH=64). It accepts one burst command (start address, length, direction), then issues one memory transaction per beat on the memory's `valid/wr_rd/addr/wdata` interface, waiting on `ready` each time. Write data is pulled from an upstream stream and read data is returned on a downstream stream with backpressure. Replaces hand-driven per-address stimulus with a reusable front-door access engine.

## Interface
- `WIDTH`, 16, data width; matches memory.
- `DEPTH`, 64, memory depth in words.
- `ADDR_WIDTH`, $clog2(DEPTH), memory address width.

- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `cmd_valid_i` in 1: burst command present.
- `cmd_ready_o` out 1: block can accept a command (high only in IDLE).
- `cmd_wr_rd_i` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr_i` in ADDR_WIDTH: start address.
- `cmd_len_i` in ADDR_WIDTH+1: beat count, 0..2*DEPTH-1.
- `wdata_valid_i` in 1 / `wdata_ready_o` out 1 / `wdata_i` in WIDTH: write-data stream.
- `rdata_valid_o` out 1 / `rdata_ready_i` in 1 / `rdata_o` out WIDTH: read-data stream.
- `mem_valid_o` out 1, `mem_wr_rd_o` out 1, `mem_addr_o` out ADDR_WIDTH, `mem_wdata_o` out WIDTH: to memory.
- `mem_rdata_i` in WIDTH, `mem_ready_i` in 1: from memory.
- `busy_o` out 1: high in any state other than IDLE.
- `done_o` out 1: one-cycle pulse at burst completion.

## Operation
- Handshake rule (all three interfaces): a transfer occurs on a rising edge where valid and ready are both high. Each valid, once asserted, holds with stable payload until its transfer.
- Memory beat completes on the edge with `mem_valid_o && mem_ready_i`. For reads, `mem_rdata_i` is sampled on that same edge.
- FSM states: IDLE, WR_FETCH, WR_ISSUE, RD_ISSUE, RD_OUT, DONE.
- IDLE: `cmd_ready_o`=1. On command transfer, latch addr, len, and direction. If len=0, go to DONE. Otherwise go to WR_FETCH (write) or RD_ISSUE (read).
- WR_FETCH: `wdata_ready_o`=1. On a wdata transfer, register the data into `mem_wdata_o` and go to WR_ISSUE.
- WR_ISSUE: `mem_valid_o`=1, `mem_wr_rd_o`=1. On a beat, go to DONE if this was the last beat, else to WR_FETCH.
- RD_ISSUE: `mem_valid_o`=1, `mem_wr_rd_o`=0. On a beat, capture `mem_rdata_i` into `rdata_o` and go to RD_OUT.
- RD_OUT: `rdata_valid_o`=1. On `rdata_ready_i`, go to DONE if this was the last beat, else to RD_ISSUE.
- DONE: `done_o`=1 for one cycle, then go to IDLE.
- Per beat: the address increments modulo DEPTH, so 63 is followed by 0. The remaining count decrements by 1.
- Lengths above DEPTH are honoured exactly; addresses wrap and overwrite earlier locations.
- Only one memory beat is outstanding at any time. `mem_addr_o` and `mem_wr_rd_o` are registered.

## Timing
- Reset values: `cmd_ready_o`=0 during reset and 1 in the first cycle after it. `wdata_ready_o`, `rdata_valid_o`, `mem_valid_o`, `mem_wr_rd_o`, `busy_o` and `done_o` are 0. `mem_addr_o`, `mem_wdata_o` and `rdata_o` are 0. State is IDLE.
- Reset asserted mid-burst: the burst is abandoned at the next edge. All outputs take their reset values, no `done_o` is produced, and no further memory beat is issued.
- Latency: `mem_valid_o` rises 1 cycle after the command transfer (read) or 1 cycle after the wdata transfer (write).
- With zero-wait peers, a write beat takes 2 cycles and a read beat takes 2 cycles.
- `done_o` fires 1 cycle after the final beat's completing transfer (mem beat for writes, rdata transfer for reads).
- len=0: `done_o` fires the cycle after the command transfer, with no memory activity.
- `cmd_valid_i` while busy: ignored, because `cmd_ready_o`=0.
- `mem_ready_i` while `mem_valid_o`=0: ignored.
- `rdata_ready_i` held low: the block stalls indefinitely in RD_OUT. `rdata_o` stays stable and no new memory read is issued.

## Test plan
- Write burst: addr=0, len=64, wdata = $random stream, `mem_ready_i` tied 1. Expect 64 memory writes to addresses 0..63 in order with matching data, then exactly one `done_o`. A backdoor dump of memory matches the stream.
- Read burst: backdoor-load memory, then addr=0, len=64, `rdata_ready_i`=1. Expect `rdata_o` to match each location in order and `done_o` once.
- Wrap-around: write addr=62, len=4. Expect `mem_addr_o` sequence 62, 63, 0, 1.
- Backpressure: read len=3 with `rdata_ready_i` low for 5 cycles on beat 2. Expect `rdata_o` held, no `mem_valid_o` during the stall, and `done_o` after the third transfer. Randomise `mem_ready_i` and `wdata_valid_i` gaps.
- len=0 command: expect no `mem_valid_o`, `done_o` 1 cycle after accept, and `cmd_ready_o` high again the following cycle.
- Reset at beat 10 of a write len=20: expect all outputs at reset values next cycle, no `done_o`, and a fresh command accepted normally afterward.
